// File: rtl/audio_clock_gen.sv
// ---------------------------------------------------------------------------
// audio_clock_gen
//
// Audio timing generator running in the PLL output clock domain.
// - Supervises PLL lock. The raw LOCK input is synchronised, and the design
//   waits for a settle period of continuous lock.
// - Sequences the downstream reset.
// - Produces BCK, LRCK and frame timing for a PCM5102-class DAC.
// Any integer BCK divider, slot width and even channel count is supported,
// so one design covers stereo I2S and TDM.
//
// Optional feature macro: LOCK_LOSS_CNT_EN
//   When defined, adds lock_loss_cnt, a saturating count of lock losses
//   seen in SETTLE, IDLE or RUN. Only the async reset clears it.
//
// Ports
//   clock_in      in   PLL output clock (sole clock)
//   reset         in   async active-high reset
//   pll_locked    in   raw PLL LOCK (asynchronous)
//   enable        in   request audio timing run (synchronous)
//   rst_out       out  active-high sync reset for downstream audio logic
//   ready         out  lock settled, timing may run
//   bck           out  bit clock level
//   bck_rise_stb  out  1-cycle pulse, first cycle with bck==1
//   bck_fall_stb  out  1-cycle pulse, first cycle with bck==0
//   lrck          out  0 = first half of frame, 1 = second half
//   frame_stb     out  pulse on the falling strobe of the first frame bit
//   slot_idx      out  current channel slot
//   bit_idx       out  current bit, SLOT_BITS-1 down to 0
//   lock_loss_cnt out  (LOCK_LOSS_CNT_EN only) lock loss event count
// ---------------------------------------------------------------------------
module audio_clock_gen #(
    parameter int BCK_DIV     = 83,
    parameter int SLOT_BITS   = 32,
    parameter int CHANNELS    = 2,
    parameter int LOCK_DELAY  = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clock_in,
    input  logic                        reset,
    input  logic                        pll_locked,
    input  logic                        enable,
    output logic                        rst_out,
    output logic                        ready,
    output logic                        bck,
    output logic                        bck_rise_stb,
    output logic                        bck_fall_stb,
    output logic                        lrck,
    output logic                        frame_stb,
    output logic [$clog2(CHANNELS)-1:0]  slot_idx,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [15:0]                 lock_loss_cnt
`endif
);

    localparam int CW  = $clog2(BCK_DIV);
    localparam int SLW = $clog2(CHANNELS);
    localparam int BW  = $clog2(SLOT_BITS);
    localparam int LW  = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

    localparam logic [CW-1:0]  C_LAST    = CW'(BCK_DIV - 1);
    localparam logic [CW-1:0]  C_HALF    = CW'(BCK_DIV / 2);
    localparam logic [BW-1:0]  B_MSB     = BW'(SLOT_BITS - 1);
    localparam logic [SLW-1:0] S_LAST    = SLW'(CHANNELS - 1);
    localparam logic [SLW-1:0] S_HALF    = SLW'(CHANNELS / 2);
    localparam logic [LW-1:0]  LOCK_LAST = LW'(LOCK_DELAY - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_SETTLE    = 2'd1,
        S_IDLE      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lk;

    state_t                 r_state, w_state_n;
    logic [LW-1:0]          r_settle, w_settle_n;
    logic [CW-1:0]          r_c, w_c_n;
    logic [BW-1:0]          r_bit, w_bit_n;
    logic [SLW-1:0]         r_slot, w_slot_n;

    logic                   w_run_n, w_ready_n;
    logic                   w_bck_n, w_rise_n, w_fall_n, w_frame_n, w_lrck_n;

    logic                   r_rst_out, r_ready, r_bck, r_rise, r_fall, r_frame, r_lrck;

    // Lock synchroniser: the last stage is the only lock signal used below.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lk = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state   <= S_WAIT_LOCK;
            r_settle  <= '0;
            r_c       <= '0;
            r_bit     <= '0;
            r_slot    <= '0;
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
            r_bck     <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_frame   <= 1'b0;
            r_lrck    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_settle  <= w_settle_n;
            r_c       <= w_c_n;
            r_bit     <= w_bit_n;
            r_slot    <= w_slot_n;
            r_rst_out <= ~w_ready_n;
            r_ready   <= w_ready_n;
            r_bck     <= w_bck_n;
            r_rise    <= w_rise_n;
            r_fall    <= w_fall_n;
            r_frame   <= w_frame_n;
            r_lrck    <= w_lrck_n;
        end
    end

    // Next state and next counter values. Counters are zero outside RUN.
    // Every registered output is decoded from these next values, so the
    // outputs line up with the counters they describe.
    always_comb begin
        w_state_n  = r_state;
        w_settle_n = '0;
        w_c_n      = '0;
        w_bit_n    = '0;
        w_slot_n   = '0;

        if (!w_lk) begin
            // A lock loss in any state aborts everything, including a frame
            // in progress.
            w_state_n = S_WAIT_LOCK;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    w_state_n = S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle == LOCK_LAST) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_settle_n = r_settle + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (enable) begin
                        // The first RUN cycle is c=0 on the MSB of slot 0.
                        w_state_n = S_RUN;
                        w_bit_n   = B_MSB;
                    end
                end
                S_RUN: begin
                    w_bit_n  = r_bit;
                    w_slot_n = r_slot;
                    if (r_c != C_LAST) begin
                        w_c_n = r_c + 1'b1;
                    end else if (r_bit != '0) begin
                        w_bit_n = r_bit - 1'b1;
                    end else begin
                        w_bit_n = B_MSB;
                        if (r_slot != S_LAST) begin
                            w_slot_n = r_slot + 1'b1;
                        end else begin
                            w_slot_n = '0;
                            // enable is only sampled at the frame boundary,
                            // so a drop followed by a reassert before this
                            // point cancels the stop.
                            if (!enable) begin
                                w_state_n = S_IDLE;
                                w_bit_n   = '0;
                            end
                        end
                    end
                end
                default: begin
                    w_state_n = S_WAIT_LOCK;
                end
            endcase
        end
    end

    assign w_run_n   = (w_state_n == S_RUN);
    assign w_ready_n = (w_state_n == S_IDLE) || (w_state_n == S_RUN);
    // Odd BCK_DIV gives the high phase the extra cycle.
    assign w_bck_n   = w_run_n && (w_c_n >= C_HALF);
    assign w_rise_n  = w_run_n && (w_c_n == C_HALF);
    assign w_fall_n  = w_run_n && (w_c_n == '0);
    assign w_frame_n = w_fall_n && (w_slot_n == '0) && (w_bit_n == B_MSB);
    assign w_lrck_n  = w_run_n && (w_slot_n >= S_HALF);

    assign rst_out      = r_rst_out;
    assign ready        = r_ready;
    assign bck          = r_bck;
    assign bck_rise_stb = r_rise;
    assign bck_fall_stb = r_fall;
    assign frame_stb    = r_frame;
    assign lrck         = r_lrck;
    assign slot_idx     = r_slot;
    assign bit_idx      = r_bit;

`ifdef LOCK_LOSS_CNT_EN
    logic        w_loss;
    logic [15:0] r_loss_cnt;

    // Entering WAIT_LOCK from WAIT_LOCK itself is not a new loss event.
    assign w_loss = !w_lk && (r_state != S_WAIT_LOCK);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_loss_cnt <= '0;
        end else if (w_loss && (r_loss_cnt != 16'hFFFF)) begin
            r_loss_cnt <= r_loss_cnt + 16'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_audio_clock_gen.sv
module tb_audio_clock_gen;

    logic clk;
    logic reset;
    logic pll_locked;
    logic enable;

    // DUT "a": BCK_DIV=4
    logic       a_rst_out, a_ready, a_bck, a_rise, a_fall, a_lrck, a_frame;
    logic       a_slot;
    logic [1:0] a_bit;
    // DUT "b": BCK_DIV=5
    logic       b_rst_out, b_ready, b_bck, b_rise, b_fall, b_lrck, b_frame;
    logic       b_slot;
    logic [1:0] b_bit;
`ifdef LOCK_LOSS_CNT_EN
    logic [15:0] a_llc, b_llc;
`endif

    int checks   = 0;
    int failures = 0;

    audio_clock_gen #(
        .BCK_DIV(4), .SLOT_BITS(4), .CHANNELS(2), .LOCK_DELAY(8), .SYNC_STAGES(2)
    ) dut_a (
        .clock_in(clk), .reset(reset), .pll_locked(pll_locked), .enable(enable),
        .rst_out(a_rst_out), .ready(a_ready), .bck(a_bck),
        .bck_rise_stb(a_rise), .bck_fall_stb(a_fall), .lrck(a_lrck),
        .frame_stb(a_frame), .slot_idx(a_slot), .bit_idx(a_bit)
`ifdef LOCK_LOSS_CNT_EN
        , .lock_loss_cnt(a_llc)
`endif
    );

    audio_clock_gen #(
        .BCK_DIV(5), .SLOT_BITS(4), .CHANNELS(2), .LOCK_DELAY(8), .SYNC_STAGES(2)
    ) dut_b (
        .clock_in(clk), .reset(reset), .pll_locked(pll_locked), .enable(enable),
        .rst_out(b_rst_out), .ready(b_ready), .bck(b_bck),
        .bck_rise_stb(b_rise), .bck_fall_stb(b_fall), .lrck(b_lrck),
        .frame_stb(b_frame), .slot_idx(b_slot), .bit_idx(b_bit)
`ifdef LOCK_LOSS_CNT_EN
        , .lock_loss_cnt(b_llc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int k;
        int bck;
        int rise;
        int fall;
        int frame;
        int lrck;
        int slot;
        int bitv;
    } vec_t;

    vec_t ta[12];
    vec_t tb[9];

    function automatic vec_t mk(int k, int b, int r, int f, int fr, int l, int s, int bi);
        vec_t v;
        v.k = k; v.bck = b; v.rise = r; v.fall = f; v.frame = fr;
        v.lrck = l; v.slot = s; v.bitv = bi;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // After pll_locked rises (or reset releases with lock present) at a
    // negedge: 2 sync edges, 1 FSM edge into SETTLE, 8 settle edges.
    task automatic check_lock_seq(input string nm);
        repeat (10) @(negedge clk);
        chk({nm, ".rst_out_hold"}, int'(a_rst_out), 1);
        chk({nm, ".ready_hold"}, int'(a_ready), 0);
        @(negedge clk);
        chk({nm, ".rst_out_rel"}, int'(a_rst_out), 0);
        chk({nm, ".ready_rel"}, int'(a_ready), 1);
        chk({nm, ".bck_idle"}, int'(a_bck), 0);
        chk({nm, ".fall_idle"}, int'(a_fall), 0);
    endtask

    initial begin
        bit got;
        int strobes;

        // BCK_DIV=4: c=k%4, bit period 4, frame 32.
        ta[0]  = mk(0,  0, 0, 1, 1, 0, 0, 3);
        ta[1]  = mk(1,  0, 0, 0, 0, 0, 0, 3);
        ta[2]  = mk(2,  1, 1, 0, 0, 0, 0, 3);
        ta[3]  = mk(3,  1, 0, 0, 0, 0, 0, 3);
        ta[4]  = mk(4,  0, 0, 1, 0, 0, 0, 2);
        ta[5]  = mk(14, 1, 1, 0, 0, 0, 0, 0);
        ta[6]  = mk(16, 0, 0, 1, 0, 1, 1, 3);
        ta[7]  = mk(19, 1, 0, 0, 0, 1, 1, 3);
        ta[8]  = mk(30, 1, 1, 0, 0, 1, 1, 0);
        ta[9]  = mk(31, 1, 0, 0, 0, 1, 1, 0);
        ta[10] = mk(32, 0, 0, 1, 1, 0, 0, 3);
        ta[11] = mk(36, 0, 0, 1, 0, 0, 0, 2);
        // BCK_DIV=5: low 2, high 3, bit period 5, frame 40.
        tb[0]  = mk(0,  0, 0, 1, 1, 0, 0, 3);
        tb[1]  = mk(1,  0, 0, 0, 0, 0, 0, 3);
        tb[2]  = mk(2,  1, 1, 0, 0, 0, 0, 3);
        tb[3]  = mk(4,  1, 0, 0, 0, 0, 0, 3);
        tb[4]  = mk(5,  0, 0, 1, 0, 0, 0, 2);
        tb[5]  = mk(7,  1, 1, 0, 0, 0, 0, 2);
        tb[6]  = mk(20, 0, 0, 1, 0, 1, 1, 3);
        tb[7]  = mk(39, 1, 0, 0, 0, 1, 1, 0);
        tb[8]  = mk(40, 0, 0, 1, 1, 0, 0, 3);

        reset = 1'b1; pll_locked = 1'b1; enable = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.rst_out", int'(a_rst_out), 1);
        chk("rst.ready", int'(a_ready), 0);
        chk("rst.bck", int'(a_bck), 0);
        chk("rst.fall", int'(a_fall), 0);
        chk("rst.bit", int'(a_bit), 0);
`ifdef LOCK_LOSS_CNT_EN
        chk("rst.llc", int'(a_llc), 0);
`endif
        reset = 1'b0;
        check_lock_seq("lock_up");

        // Run: table-driven for both dividers
        enable = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 40; k++) begin
            foreach (ta[i]) if (ta[i].k == k) begin
                chk($sformatf("a.k%0d.bck", k),   int'(a_bck),   ta[i].bck);
                chk($sformatf("a.k%0d.rise", k),  int'(a_rise),  ta[i].rise);
                chk($sformatf("a.k%0d.fall", k),  int'(a_fall),  ta[i].fall);
                chk($sformatf("a.k%0d.frame", k), int'(a_frame), ta[i].frame);
                chk($sformatf("a.k%0d.lrck", k),  int'(a_lrck),  ta[i].lrck);
                chk($sformatf("a.k%0d.slot", k),  int'(a_slot),  ta[i].slot);
                chk($sformatf("a.k%0d.bit", k),   int'(a_bit),   ta[i].bitv);
            end
            foreach (tb[i]) if (tb[i].k == k) begin
                chk($sformatf("b.k%0d.bck", k),   int'(b_bck),   tb[i].bck);
                chk($sformatf("b.k%0d.rise", k),  int'(b_rise),  tb[i].rise);
                chk($sformatf("b.k%0d.fall", k),  int'(b_fall),  tb[i].fall);
                chk($sformatf("b.k%0d.frame", k), int'(b_frame), tb[i].frame);
                chk($sformatf("b.k%0d.lrck", k),  int'(b_lrck),  tb[i].lrck);
                chk($sformatf("b.k%0d.slot", k),  int'(b_slot),  tb[i].slot);
                chk($sformatf("b.k%0d.bit", k),   int'(b_bit),   tb[i].bitv);
            end
            @(negedge clk);
        end

        // Stop request at slot 0 bit 2: frame completes, then IDLE
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            if (a_frame) got = 1'b1;
            else @(negedge clk);
        end
        chk("stop.frame_found", int'(got), 1);
        repeat (4) @(negedge clk);
        chk("stop.k4_fall", int'(a_fall), 1);
        chk("stop.k4_bit", int'(a_bit), 2);
        enable = 1'b0;
        repeat (27) @(negedge clk);
        chk("stop.k31_bck", int'(a_bck), 1);
        chk("stop.k31_slot", int'(a_slot), 1);
        chk("stop.k31_bit", int'(a_bit), 0);
        @(negedge clk);
        chk("stop.k32_frame", int'(a_frame), 0);
        chk("stop.k32_fall", int'(a_fall), 0);
        chk("stop.k32_bck", int'(a_bck), 0);
        chk("stop.k32_bit", int'(a_bit), 0);
        chk("stop.k32_ready", int'(a_ready), 1);
        strobes = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            strobes += int'(a_fall) + int'(a_rise) + int'(a_frame) + int'(a_bck);
        end
        chk("stop.quiet", strobes, 0);

        // Re-enable: first fall strobe is a frame strobe
        enable = 1'b1;
        @(negedge clk);
        chk("reen.fall", int'(a_fall), 1);
        chk("reen.frame", int'(a_frame), 1);
        chk("reen.bit", int'(a_bit), 3);

        // Drop and reassert before frame end cancels the stop
        repeat (8) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        chk("cancel.frame", int'(a_frame), 1);
        chk("cancel.bck", int'(a_bck), 0);

        // Lock loss mid-frame
        repeat (8) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        chk("loss.e2_rst_out", int'(a_rst_out), 0);
        @(negedge clk);
        chk("loss.e3_rst_out", int'(a_rst_out), 1);
        chk("loss.e3_ready", int'(a_ready), 0);
        chk("loss.e3_bck", int'(a_bck), 0);
        chk("loss.e3_rise", int'(a_rise), 0);
        chk("loss.e3_bit", int'(a_bit), 0);
        chk("loss.e3_slot", int'(a_slot), 0);
        chk("loss.b_rst_out", int'(b_rst_out), 1);
`ifdef LOCK_LOSS_CNT_EN
        chk("loss.llc1", int'(a_llc), 1);
`endif
        enable = 1'b0;

        // Relock with a one-cycle glitch during SETTLE, then a clean settle
        pll_locked = 1'b1;
        repeat (6) @(negedge clk);
        chk("glitch.in_settle", int'(a_rst_out), 1);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        check_lock_seq("relock");
`ifdef LOCK_LOSS_CNT_EN
        chk("relock.llc2", int'(a_llc), 2);
`endif

        // Async reset mid-RUN
        enable = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst.pre_ready", int'(a_ready), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst.rst_out", int'(a_rst_out), 1);
        chk("arst.ready", int'(a_ready), 0);
        chk("arst.bck", int'(a_bck), 0);
        chk("arst.lrck", int'(a_lrck), 0);
        chk("arst.bit", int'(a_bit), 0);
        chk("arst.fall", int'(a_fall), 0);
        chk("arst.b_ready", int'(b_ready), 0);
`ifdef LOCK_LOSS_CNT_EN
        chk("arst.llc", int'(a_llc), 0);
`endif
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_lock_seq("reset_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
